counter_seq_ctrl: RTL and testbench

Sequencer that owns a small up-counter and runs it as a programmable timer. It captures a terminal count and a prescale value, then runs the counter as either a one-shot or a periodic timer. It emits a one-cycle tick at each terminal event and a one-cycle done at one-shot completion. It sits between control logic (start/stop) and any consumer of the count value or the tick/done pulses.

---
 rtl/counter_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_counter_seq_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl
// Programmable timer sequencer. It owns an up-counter and a prescaler and runs
// them as a one-shot or periodic timer. term_cnt, prescale and periodic are
// captured into shadow registers when a run starts.
//
// Ports:
//   clk       - system clock; all state updates on the rising edge
//   rstn      - asynchronous active-low reset
//   start     - level-sampled run request; honoured only in IDLE
//   stop      - level-sampled abort; honoured in RUN, and blocks start in IDLE
//   periodic  - 1 = auto-reload at terminal, 0 = one-shot (captured at start)
//   term_cnt  - terminal count value (captured at start)
//   prescale  - count advances every prescale+1 cycles (captured at start)
//   count     - current counter value (registered)
//   busy      - high while in RUN
//   tick      - one-cycle pulse on each terminal event
//   done      - one-cycle pulse when a one-shot run completes
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] term_cnt,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [WIDTH-1:0]   term_sh_q, term_sh_d;
  logic [PRE_W-1:0]   pre_sh_q, pre_sh_d;
  logic               per_sh_q, per_sh_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      pre_q     <= '0;
      term_sh_q <= '0;
      pre_sh_q  <= '0;
      per_sh_q  <= 1'b0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      term_sh_q <= term_sh_d;
      pre_sh_q  <= pre_sh_d;
      per_sh_q  <= per_sh_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    pre_d     = pre_q;
    term_sh_d = term_sh_q;
    pre_sh_d  = pre_sh_q;
    per_sh_d  = per_sh_q;
    tick_d    = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // stop has priority over start even while idle
        if (start && !stop) begin
          term_sh_d = term_cnt;
          pre_sh_d  = prescale;
          per_sh_d  = periodic;
          count_d   = '0;
          pre_d     = '0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // abort: count freezes, and a coinciding terminal event is dropped
          state_d = IDLE;
          pre_d   = '0;
        end else if (pre_q != pre_sh_q) begin
          pre_d = pre_q + PRE_W'(1);
        end else begin
          pre_d = '0;
          if (count_q == term_sh_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (!per_sh_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign tick  = tick_q;
  assign done  = done_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start, stop, periodic;
  logic [WIDTH-1:0] term_cnt;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             busy, tick, done;

  int n_chk  = 0;
  int n_fail = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .term_cnt (term_cnt),
    .prescale (prescale),
    .count    (count),
    .busy     (busy),
    .tick     (tick),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Reference model: elapsed edges since start; count and terminal events
  // follow arithmetically from n, T and P.
  bit m_run;
  int m_n, m_t, m_p, m_count;
  bit m_per, m_tick, m_done;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_run = 0; m_n = 0; m_t = 0; m_p = 0; m_per = 0;
      m_count = 0; m_tick = 0; m_done = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (!m_run) begin
        if (start && !stop) begin
          m_t = int'(term_cnt); m_p = int'(prescale); m_per = periodic;
          m_n = 0; m_count = 0; m_run = 1;
        end
      end else if (stop) begin
        m_run = 0;
      end else begin
        m_n++;
        m_count = (m_n / (m_p + 1)) % (m_t + 1);
        if (m_n % ((m_t + 1) * (m_p + 1)) == 0) begin
          m_tick = 1;
          if (!m_per) begin
            m_run = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Advance to the next falling edge and compare every output with the model.
  task automatic cyc();
    @(negedge clk);
    chk("count", 32'(count), 32'(m_count));
    chk("busy",  32'(busy),  32'(m_run));
    chk("tick",  32'(tick),  32'(m_tick));
    chk("done",  32'(done),  32'(m_done));
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic pulse_start(input logic [WIDTH-1:0] t, input logic [PRE_W-1:0] p,
                             input logic per);
    term_cnt = t; prescale = p; periodic = per; start = 1'b1;
    cyc();            // start edge has occurred
    start = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b1; stop = 1'b0; periodic = 1'b0;
    term_cnt = '0; prescale = '0;

    // 1. reset held with start high
    cycles(2);
    chk("rst_count", 32'(count), 0);
    chk("rst_busy",  32'(busy),  0);
    rstn = 1'b1; start = 1'b0;
    cycles(2);
    chk("rst_exit_busy", 32'(busy), 0);
    chk("rst_exit_tick", 32'(tick | done), 0);

    // 2. one-shot T=3 P=0
    pulse_start(4'd3, 4'd0, 1'b0);
    chk("os_busy0",  32'(busy),  1);
    chk("os_count0", 32'(count), 0);
    cyc(); chk("os_c1", 32'(count), 1);
    cyc(); chk("os_c2", 32'(count), 2);
    cyc(); chk("os_c3", 32'(count), 3);
    cyc();
    chk("os_term_count", 32'(count), 0);
    chk("os_tick", 32'(tick), 1);
    chk("os_done", 32'(done), 1);
    chk("os_busy", 32'(busy), 0);
    cyc();
    chk("os_pulse_end", 32'(tick | done), 0);

    // 3. periodic T=2 P=1: 0,0,1,1,2,2,0 with tick every 6
    pulse_start(4'd2, 4'd1, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      cyc();
      chk("per_count", 32'(count), 32'((k / 2) % 3));
      chk("per_tick",  32'(tick),  32'((k % 6) == 0));
      chk("per_done",  32'(done),  0);
      chk("per_busy",  32'(busy),  1);
    end
    stop = 1'b1; cyc(); stop = 1'b0;

    // 4. stop mid-run at count 5, then restart
    pulse_start(4'd9, 4'd0, 1'b0);
    cycles(5);
    chk("stop_pre", 32'(count), 5);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_count", 32'(count), 5);
    chk("stop_busy",  32'(busy),  0);
    chk("stop_pulse", 32'(tick | done), 0);
    cycles(2);
    chk("stop_frozen", 32'(count), 5);
    start = 1'b1; stop = 1'b1;  // stop beats start in IDLE
    cyc();
    chk("idle_stop_wins", 32'(busy), 0);
    stop = 1'b0;
    cyc();                      // start edge
    start = 1'b0;
    chk("restart_count", 32'(count), 0);
    chk("restart_busy",  32'(busy),  1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // 5. wrap at 15, then stop coinciding with terminal
    pulse_start(4'd15, 4'd0, 1'b1);
    cycles(15);
    chk("wrap_15", 32'(count), 15);
    cyc();
    chk("wrap_0",    32'(count), 0);
    chk("wrap_tick", 32'(tick),  1);
    cycles(15);
    chk("wrap2_15", 32'(count), 15);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("prio_tick",  32'(tick),  0);
    chk("prio_busy",  32'(busy),  0);
    chk("prio_count", 32'(count), 15);

    // 6. shadowing and async reset mid-run
    pulse_start(4'd3, 4'd0, 1'b0);
    term_cnt = 4'd7;
    cycles(3);
    cyc();
    chk("shadow_tick", 32'(tick), 1);
    chk("shadow_done", 32'(done), 1);
    pulse_start(4'd12, 4'd2, 1'b1);
    cycles(7);
    chk("pre_rst_busy", 32'(busy), 1);
    #7 rstn = 1'b0;            // between edges
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_busy",  32'(busy),  0);
    chk("arst_pulse", 32'(tick | done), 0);
    cyc();
    rstn = 1'b1;
    cycles(2);
    chk("arst_idle", 32'(busy), 0);

    // randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      start    = ($urandom_range(0, 3) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      term_cnt = WIDTH'($urandom);
      prescale = PRE_W'($urandom_range(0, 3));
      periodic = 1'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
